mac16_dot_seq: RTL and testbench
================================

# mac16_dot_seq

Sequencer that time-shares one SB_MAC16 configured as a 16x16 multiply-accumulator to compute dot products. Accepts a job (length, optional subtract), streams operand pairs into the MAC, and drives its load, hold and add/sub controls around the multiplier pipeline. Captures the 32-bit accumulator into a result register with a valid/ready handshake. Sits between operand-producing logic and the DSP tile.

## Interface
- `LEN_W`, 10: job length counter width; max job length 2^LEN_W-1.
- `MAC_LAT`, 3: cycles from a `mac_a`/`mac_b` update until the product is valid at the MAC accumulator input. Range 1..8. Value 3 matches A_REG=B_REG=1, PIPELINE_16x16_MULT_REG1=1, PIPELINE_16x16_MULT_REG2=1.
- `CLK` in 1: single clock, rising edge.
- `RSTN` in 1: asynchronous active-low reset.
- `start_valid`, `start_ready` in/out 1: job handshake.
- `start_len` in LEN_W: number of operand pairs in the job.
- `start_sub` in 1: subtract products instead of adding them.
- `in_valid`, `in_ready` in/out 1: operand handshake.
- `in_a`, `in_b` in 16: operands.
- `res_valid`, `res_ready` out/in 1: result handshake.
- `res_data` out 32: dot product, modulo 2^32.
- `mac_a`, `mac_b` out 16: to MAC A/B.
- `mac_oload` out 1: to OLOADTOP/OLOADBOT. The MAC C/D inputs are tied to 0.
- `mac_ohold` out 1: to OHOLDTOP/OHOLDBOT.
- `mac_addsub` out 1: to ADDSUBTOP/ADDSUBBOT.
- `mac_ce` out 1: MAC CE. Held at 1 outside reset.
- `mac_o` in 32: MAC O output, using the accumulator-register output select.

## Operation
- FSM states:
  - IDLE: `start_ready`=1 when `res_valid`=0, or when `res_valid`&`res_ready` in the same cycle. On a start handshake, latch `start_len` into `remaining` and `start_sub` into `sub_q`, then go to CLEAR.
  - CLEAR: one cycle with `mac_oload`=1 and `mac_ohold`=0, so the accumulator loads 0. Go to FEED, or to DRAIN if `remaining`=0.
  - FEED: `in_ready`=1. Each handshake registers `in_a`/`in_b` into `mac_a`/`mac_b`, shifts a 1 into the MAC_LAT-deep `vpipe` and decrements `remaining`. Cycles without a handshake shift in 0 and keep the previous `mac_a`/`mac_b`. When the last pair is accepted, go to DRAIN.
  - DRAIN: shift 0s until `vpipe` is empty, wait one more cycle for the accumulator to update, then go to DONE.
  - DONE: one cycle. `res_data` <= `mac_o`, `res_valid` <= 1, then go to IDLE.
- `mac_ohold` = ~`vpipe[MAC_LAT-1]` in FEED and DRAIN, 0 in CLEAR, 1 in IDLE and DONE.
- `mac_addsub` = `sub_q` from CLEAR through DONE, 0 otherwise.
- `res_valid` falls on a `res_valid`&`res_ready` cycle.
- The result register is independent of the MAC, so a new job can start while an old result is pending only as allowed by the IDLE rule.
- Products are signed or unsigned per MAC parameters. This block never interprets data.
- Reset values: `start_ready`=0 while in reset, 1 from the first cycle after release. All other outputs 0 except `mac_ohold`=1 and `mac_ce`=0. Release to IDLE.
- Reset mid-job: job, pipeline and pending result are discarded. The MAC's own registers are not reset by this block.

## Timing
- Operand accepted at edge e:
  - `mac_a`/`mac_b` update at e.
  - `mac_ohold`=0 during the cycle after edge e+MAC_LAT.
  - Accumulator updates at e+MAC_LAT+1.
- Job latency with no stalls, from start handshake edge S with N pairs:
  - CLEAR at S..S+1, FEED accepts pairs at S+2..S+N+1.
  - `res_valid` rises at edge S+N+MAC_LAT+4.
- N=0: `res_valid` rises at S+4 with `res_data`=0.
- FEED throughput is one pair per cycle. `in_ready` stays high in FEED regardless of `in_valid`.
- `in_ready`=0 outside FEED. Operand beats offered outside FEED are not consumed.

## Configuration
- `MAC16_DOT_SUB_EN` defined: `start_sub` is honoured, and `mac_addsub` follows `sub_q`, giving the result 0 − Σ a·b.
- Not defined: `start_sub` is ignored, `sub_q` and its logic are removed, and `mac_addsub` is constant 0.

## Test plan
- Reset: assert `RSTN`=0 mid-FEED → all outputs at reset values. After release, the next job of len 2, (3,4),(5,6), gives `res_data`=0x0000002A.
- Back-to-back jobs: len 4, all pairs (0x0100,0x0100), then len 1, (2,3) → results 0x00040000 then 0x00000006. The second result proves CLEAR works.
- Stalls: len 3 with `in_valid` gaps of 0, 2 and 5 cycles, pairs (1,1),(2,2),(3,3) → result 14, with `res_valid` delayed by exactly the 7 gap cycles.
- Zero length: `start_len`=0 → `res_valid` at S+4 with `res_data`=0. No `in_ready` pulse.
- Result backpressure: hold `res_ready`=0 for 10 cycles → `start_ready` stays 0 and `res_data` is stable. Asserting `res_ready` together with `start_valid` accepts the next job in the same cycle.
- `MAC16_DOT_SUB_EN` defined: `start_sub`=1, len 2, (3,4),(1,2) → `res_data`=0xFFFFFFF2 (−14).

Source files
------------

// File: rtl/mac16_dot_seq_if.sv
// Handshake and DSP-tile bundle for mac16_dot_seq.
// slave = the sequencer; master = operand producer / result consumer / SB_MAC16 side.
interface mac16_dot_seq_if #(
  parameter int LEN_W = 10
);
  logic             start_valid;
  logic             start_ready;
  logic [LEN_W-1:0] start_len;
  logic             start_sub;

  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a;
  logic [15:0]      in_b;

  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;

  logic [15:0]      mac_a;
  logic [15:0]      mac_b;
  logic             mac_oload;
  logic             mac_ohold;
  logic             mac_addsub;
  logic             mac_ce;
  logic [31:0]      mac_o;

  modport slave (
    input  start_valid, start_len, start_sub, in_valid, in_a, in_b, res_ready, mac_o,
    output start_ready, in_ready, res_valid, res_data,
           mac_a, mac_b, mac_oload, mac_ohold, mac_addsub, mac_ce
  );

  modport master (
    output start_valid, start_len, start_sub, in_valid, in_a, in_b, res_ready, mac_o,
    input  start_ready, in_ready, res_valid, res_data,
           mac_a, mac_b, mac_oload, mac_ohold, mac_addsub, mac_ce
  );
endinterface

// File: rtl/mac16_dot_seq.sv
// Dot-product sequencer time-sharing one SB_MAC16 16x16 multiply-accumulator.
// Define MAC16_DOT_SUB_EN to honour start_sub (accumulate 0 - sum(a*b)).
module mac16_dot_seq #(
  parameter int LEN_W   = 10,
  parameter int MAC_LAT = 3
) (
  input logic           CLK,
  input logic           RSTN,
  mac16_dot_seq_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t             r_state;
  logic               r_alive;
  logic [LEN_W-1:0]   r_remaining;
  logic [MAC_LAT-1:0] r_vpipe;
  logic               r_drain_wait;
  logic               r_in_ready;
  logic               r_oload;
  logic               r_ohold;
  logic               r_res_valid;
  logic [31:0]        r_res_data;
  logic [15:0]        r_mac_a;
  logic [15:0]        r_mac_b;

  logic w_start_ready;
  logic w_start_hs;
  logic w_in_hs;
  logic w_res_hs;
  logic w_vtop;

  // A pending result may be handed off in the same cycle a new job is accepted.
  assign w_start_ready = r_alive && (r_state == S_IDLE) && (!r_res_valid || bus.res_ready);
  assign w_start_hs    = w_start_ready && bus.start_valid;
  assign w_in_hs       = r_in_ready && bus.in_valid;
  assign w_res_hs      = r_res_valid && bus.res_ready;
  assign w_vtop        = r_vpipe[MAC_LAT-1];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state      <= S_IDLE;
      r_alive      <= 1'b0;
      r_remaining  <= '0;
      r_vpipe      <= '0;
      r_drain_wait <= 1'b0;
      r_in_ready   <= 1'b0;
      r_oload      <= 1'b0;
      r_ohold      <= 1'b1;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_mac_a      <= '0;
      r_mac_b      <= '0;
    end else begin
      r_alive <= 1'b1;
      r_vpipe <= (r_vpipe << 1) | MAC_LAT'(w_in_hs);
      if (w_res_hs) r_res_valid <= 1'b0;

      // ohold is registered from the pipe tail, so the accumulator opens
      // exactly MAC_LAT+1 edges after an operand lands on mac_a/mac_b.
      case (r_state)
        S_IDLE: begin
          if (w_start_hs) begin
            r_remaining <= bus.start_len;
            r_state     <= S_CLEAR;
            r_oload     <= 1'b1;
            r_ohold     <= 1'b0;
          end
        end
        S_CLEAR: begin
          r_oload      <= 1'b0;
          r_drain_wait <= 1'b0;
          r_ohold      <= ~w_vtop;
          if (r_remaining == '0) begin
            r_state <= S_DRAIN;
          end else begin
            r_state    <= S_FEED;
            r_in_ready <= 1'b1;
          end
        end
        S_FEED: begin
          r_ohold <= ~w_vtop;
          if (w_in_hs) begin
            r_mac_a     <= bus.in_a;
            r_mac_b     <= bus.in_b;
            r_remaining <= r_remaining - LEN_W'(1);
            if (r_remaining == LEN_W'(1)) begin
              r_state    <= S_DRAIN;
              r_in_ready <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          // Pipe empty, then one extra cycle for the last accumulate to land.
          if ((r_vpipe == '0) && r_drain_wait) begin
            r_state <= S_DONE;
            r_ohold <= 1'b1;
          end else begin
            r_ohold <= ~w_vtop;
            if (r_vpipe == '0) r_drain_wait <= 1'b1;
          end
        end
        S_DONE: begin
          r_res_data  <= bus.mac_o;
          r_res_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MAC16_DOT_SUB_EN
  logic r_sub_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)                  r_sub_q <= 1'b0;
    else if (w_start_hs)        r_sub_q <= bus.start_sub;
    else if (r_state == S_DONE) r_sub_q <= 1'b0;
  end

  assign bus.mac_addsub = r_sub_q;
`else
  assign bus.mac_addsub = 1'b0;
`endif

  assign bus.start_ready = w_start_ready;
  assign bus.in_ready    = r_in_ready;
  assign bus.res_valid   = r_res_valid;
  assign bus.res_data    = r_res_data;
  assign bus.mac_a       = r_mac_a;
  assign bus.mac_b       = r_mac_b;
  assign bus.mac_oload   = r_oload;
  assign bus.mac_ohold   = r_ohold;
  assign bus.mac_ce      = r_alive;

endmodule

// File: tb/tb_mac16_dot_seq.sv
// Directed bench for mac16_dot_seq with a behavioural SB_MAC16 accumulator model
// and a result scoreboard.
module tb_mac16_dot_seq;
  localparam int LEN_W   = 10;
  localparam int MAC_LAT = 3;
`ifdef MAC16_DOT_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic CLK  = 1'b0;
  logic RSTN = 1'b0;
  always #5 CLK = ~CLK;

  mac16_dot_seq_if #(.LEN_W(LEN_W)) bus ();

  mac16_dot_seq #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus.slave)
  );

  // SB_MAC16 model: A/B regs plus multiplier pipeline, C/D tied to 0, accumulator output.
  logic [31:0] m_p [MAC_LAT];
  logic [31:0] m_acc = 32'h0;
  initial for (int k = 0; k < MAC_LAT; k++) m_p[k] = 32'h0;
  always @(posedge CLK) begin
    if (bus.mac_ce) begin
      m_p[0] <= 32'(bus.mac_a) * 32'(bus.mac_b);
      for (int k = 1; k < MAC_LAT; k++) m_p[k] <= m_p[k-1];
      if (!bus.mac_ohold)
        m_acc <= bus.mac_oload ? 32'h0 :
                 (bus.mac_addsub ? m_acc - m_p[MAC_LAT-1] : m_acc + m_p[MAC_LAT-1]);
    end
  end
  assign bus.mac_o = m_acc;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          s_edge   = 0;
  logic [31:0] sb[$];
  logic        saw_in_ready = 1'b0;
  logic [15:0] ja [8];
  logic [15:0] jb [8];
  int          jgap [8];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Result monitor: a handshake seen here completes at the next rising edge.
  always begin
    @(negedge CLK);
    #1;
    if (bus.in_ready) saw_in_ready = 1'b1;
    if (RSTN && bus.res_valid && bus.res_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL sb_unexpected_result observed=0x%08h expected=none", bus.res_data);
      end else begin
        chk("res_data", bus.res_data, sb.pop_front());
      end
    end
  end

  task automatic chk_reset(input string t);
    chk({t, ".start_ready"}, 32'(bus.start_ready), 32'd0);
    chk({t, ".in_ready"},    32'(bus.in_ready),    32'd0);
    chk({t, ".res_valid"},   32'(bus.res_valid),   32'd0);
    chk({t, ".res_data"},    bus.res_data,         32'd0);
    chk({t, ".mac_a"},       32'(bus.mac_a),       32'd0);
    chk({t, ".mac_b"},       32'(bus.mac_b),       32'd0);
    chk({t, ".mac_oload"},   32'(bus.mac_oload),   32'd0);
    chk({t, ".mac_ohold"},   32'(bus.mac_ohold),   32'd1);
    chk({t, ".mac_addsub"},  32'(bus.mac_addsub),  32'd0);
    chk({t, ".mac_ce"},      32'(bus.mac_ce),      32'd0);
  endtask

  task automatic start_job(input int len, input bit sub);
    logic [31:0] sum;
    int n;
    sum = 32'h0;
    n   = 0;
    for (int i = 0; i < len; i++) sum = sum + 32'(ja[i]) * 32'(jb[i]);
    sb.push_back((SUB_EN && sub) ? 32'h0 - sum : sum);
    bus.start_len   = LEN_W'(len);
    bus.start_sub   = sub;
    bus.start_valid = 1'b1;
    #1;
    while (!bus.start_ready && n < 200) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk("start_hs_in_time", 32'(n < 200), 32'd1);
    @(negedge CLK);
    s_edge          = cyc;
    bus.start_valid = 1'b0;
  endtask

  task automatic feed(input int cnt);
    int n;
    for (int i = 0; i < cnt; i++) begin
      bus.in_valid = 1'b0;
      repeat (jgap[i]) @(negedge CLK);
      bus.in_valid = 1'b1;
      bus.in_a     = ja[i];
      bus.in_b     = jb[i];
      n = 0;
      while (!bus.in_ready && n < 100) begin
        @(negedge CLK);
        n++;
      end
      chk("in_hs_in_time", 32'(n < 100), 32'd1);
      @(negedge CLK);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input int exp_lat, input string t);
    int n;
    n = 0;
    while (!bus.res_valid && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chk({t, ".res_in_time"}, 32'(n < 300), 32'd1);
    chk({t, ".latency"}, 32'(cyc - s_edge), 32'(exp_lat));
  endtask

  task automatic set_pair(input int i, input logic [15:0] a, input logic [15:0] b, input int gap);
    ja[i]   = a;
    jb[i]   = b;
    jgap[i] = gap;
  endtask

  initial begin
    int c0;
    bus.start_valid = 1'b0;
    bus.start_len   = '0;
    bus.start_sub   = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_a        = '0;
    bus.in_b        = '0;
    bus.res_ready   = 1'b1;
    for (int i = 0; i < 8; i++) set_pair(i, 16'h0, 16'h0, 0);

    repeat (3) @(negedge CLK);
    #1 chk_reset("rst0");
    @(negedge CLK) RSTN = 1'b1;
    @(negedge CLK);
    #1;
    chk("rel.start_ready", 32'(bus.start_ready), 32'd1);
    chk("rel.mac_ce",      32'(bus.mac_ce),      32'd1);

    // Back-to-back: 4 x 0x100*0x100, then 2*3 proves the accumulator is cleared.
    for (int i = 0; i < 4; i++) set_pair(i, 16'h0100, 16'h0100, 0);
    start_job(4, 1'b0);
    feed(4);
    wait_result(4 + MAC_LAT + 4, "b2b_a");
    set_pair(0, 16'd2, 16'd3, 0);
    start_job(1, 1'b0);
    feed(1);
    wait_result(1 + MAC_LAT + 4, "b2b_b");

    // Input stalls of 0, 2 and 5 cycles delay the result by exactly 7.
    set_pair(0, 16'd1, 16'd1, 0);
    set_pair(1, 16'd2, 16'd2, 2);
    set_pair(2, 16'd3, 16'd3, 5);
    start_job(3, 1'b0);
    feed(3);
    wait_result(3 + MAC_LAT + 4 + 7, "stall");

    // Zero-length job never opens the operand port.
    saw_in_ready = 1'b0;
    start_job(0, 1'b0);
    wait_result(4, "zero");
    chk("zero.no_in_ready", 32'(saw_in_ready), 32'd0);

    // Reset in the middle of FEED discards the job.
    for (int i = 0; i < 5; i++) set_pair(i, 16'(i + 1), 16'(i + 2), 0);
    start_job(5, 1'b0);
    feed(2);
    RSTN            = 1'b0;
    bus.in_valid    = 1'b0;
    bus.start_valid = 1'b0;
    sb.delete();
    #1 chk_reset("rst_mid");
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);
    #1 chk("rel2.start_ready", 32'(bus.start_ready), 32'd1);

    // Result backpressure, then a job accepted in the result-handshake cycle.
    bus.res_ready = 1'b0;
    set_pair(0, 16'd3, 16'd4, 0);
    set_pair(1, 16'd5, 16'd6, 0);
    start_job(2, 1'b0);
    feed(2);
    wait_result(2 + MAC_LAT + 4, "bp");
    repeat (10) begin
      @(negedge CLK);
      #1;
      chk("bp.start_ready", 32'(bus.start_ready), 32'd0);
      chk("bp.res_valid",   32'(bus.res_valid),   32'd1);
      chk("bp.res_data",    bus.res_data,         32'h0000002A);
    end
    @(negedge CLK);
    bus.res_ready = 1'b1;
    set_pair(0, 16'd7, 16'd8, 0);
    c0 = cyc;
    start_job(1, 1'b0);
    chk("bp.same_cycle_start", 32'(s_edge), 32'(c0 + 1));
    feed(1);
    wait_result(1 + MAC_LAT + 4, "bp_next");

    // Subtract job; without the feature start_sub is ignored.
    set_pair(0, 16'd3, 16'd4, 0);
    set_pair(1, 16'd1, 16'd2, 0);
    start_job(2, 1'b1);
    #1 chk("sub.mac_addsub", 32'(bus.mac_addsub), 32'(SUB_EN));
    feed(2);
    wait_result(2 + MAC_LAT + 4, "sub");
    @(negedge CLK);
    #1 chk("sub.addsub_idle", 32'(bus.mac_addsub), 32'd0);

    repeat (3) @(negedge CLK);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
